// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared fetch-side types and constants for the 5-stage pipeline.
package if_fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [XLEN-1:0] NOP_INSTR = '0;
    typedef enum logic [1:0] {REQ, HOLD, KILL} fetch_state_e;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;
endpackage

// File: rtl/if_fetch_unit_ifid.sv
// ifid_pipe_reg: IF/ID pipeline register; clear beats load, load beats bubble.
module ifid_pipe_reg
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               bubble,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [ADDR_W-1:0]  d_pc4,
    input  logic [INSTR_W-1:0] d_instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc4,
    output logic [INSTR_W-1:0] instr,
    output logic               valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            pc4   <= '0;
            instr <= '0;
            valid <= 1'b0;
        end else if (clear || (bubble && !load)) begin
            instr <= INSTR_W'(NOP_INSTR);
            valid <= 1'b0;
        end else if (load) begin
            pc    <= d_pc;
            pc4   <= d_pc4;
            instr <= d_instr;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, imem req/ack handshake and IF/ID register with stall/flush handling.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               pc_write_i,
    input  logic               ifid_write_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0]  ifid_pc_o,
    output logic [ADDR_W-1:0]  ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               ifid_valid_o,
    output logic               fetch_busy_o
);
    fetch_state_e       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next4;
    logic [ADDR_W-1:0]  kill_addr;
    logic [INSTR_W-1:0] hold_buf;
    logic               stall;
    logic               ack_req;
    logic               ifid_load;
    logic               ifid_bubble;

    assign stall        = !pc_write_i || !ifid_write_i;
    assign ack_req      = state == REQ && imem_ack_i;
    assign ifid_load    = !flush_i && !stall && (ack_req || state == HOLD);
    assign ifid_bubble  = ifid_write_i && state != HOLD && !ack_req;
    assign pc_next4     = pc + ADDR_W'(4);
    assign imem_req_o   = state != HOLD;
    assign fetch_busy_o = imem_req_o;
    // While killing, the request must stay on the address it was issued with.
    assign imem_addr_o  = state == KILL ? kill_addr : pc;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= REQ;
            pc        <= RESET_PC;
            kill_addr <= RESET_PC;
            hold_buf  <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (flush_i) begin
                        pc <= branch_target_i;
                        if (!imem_ack_i) begin
                            kill_addr <= pc;
                            state     <= KILL;
                        end
                    end else if (imem_ack_i) begin
                        if (stall) begin
                            hold_buf <= imem_rdata_i;
                            state    <= HOLD;
                        end else begin
                            pc <= pc_next4;
                        end
                    end
                end
                HOLD: begin
                    if (flush_i) begin
                        pc    <= branch_target_i;
                        state <= REQ;
                    end else if (!stall) begin
                        pc    <= pc_next4;
                        state <= REQ;
                    end
                end
                KILL: begin
                    if (flush_i) pc <= branch_target_i;
                    if (imem_ack_i) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

    ifid_pipe_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_ifid (
        .clk     (clk_i),
        .rst_n   (rst_n),
        .load    (ifid_load),
        .bubble  (ifid_bubble),
        .clear   (flush_i),
        .d_pc    (pc),
        .d_pc4   (pc_next4),
        .d_instr (state == HOLD ? hold_buf : imem_rdata_i),
        .pc      (ifid_pc_o),
        .pc4     (ifid_pc4_o),
        .instr   (ifid_instr_o),
        .valid   (ifid_valid_o)
    );

    no_ack_in_hold: assert property (@(posedge clk_i) disable iff (!rst_n) !(state == HOLD && imem_ack_i));
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random stall/flush/latency stimulus checked against a program-order fetch model.
module tb_if_fetch_unit;
    logic        clk = 0;
    logic        rst_n;
    logic        pc_write, ifid_write, flush;
    logic [31:0] target;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] ifid_pc, ifid_pc4, ifid_instr;
    logic        ifid_valid, fetch_busy;

    int checks = 0;
    int passed = 0;
    int lat;
    int rem = 0;
    bit stream_on;

    // Model: next fetch address, a parked instruction, and a pending wrong-path request.
    logic [31:0] m_pc, m_hbuf, m_kaddr, s_ptr;
    logic [31:0] e_pc, e_pc4, e_instr;
    bit          m_held, m_kill, m_st, e_valid;

    if_fetch_unit dut (
        .clk_i(clk), .rst_n(rst_n), .pc_write_i(pc_write), .ifid_write_i(ifid_write),
        .flush_i(flush), .branch_target_i(target), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata), .ifid_pc_o(ifid_pc), .ifid_pc4_o(ifid_pc4),
        .ifid_instr_o(ifid_instr), .ifid_valid_o(ifid_valid), .fetch_busy_o(fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[17:2]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic ifid_is(input string name, input logic [31:0] a);
        chk({name, "_pc"}, ifid_pc, a);
        chk({name, "_pc4"}, ifid_pc4, a + 32'd4);
        chk({name, "_instr"}, ifid_instr, mem(a));
        chk({name, "_valid"}, {31'd0, ifid_valid}, 32'd1);
    endtask

    task automatic deliver(input logic [31:0] d);
        e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_instr = d; e_valid = 1;
        m_pc = m_pc + 32'd4; m_held = 0;
    endtask

    // Memory: acks lat cycles after a request starts (lat 0 = random 1..4).
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            imem_ack = 0; rem = 0;
        end else if (imem_req) begin
            if (rem == 0) rem = lat != 0 ? lat : $urandom_range(1, 4);
            imem_ack = rem == 1;
            imem_rdata = imem_ack ? mem(imem_addr) : $urandom;
            rem--;
        end else begin
            imem_ack = 0; imem_rdata = $urandom;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_hbuf = 0; m_kaddr = 0; m_held = 0; m_kill = 0; s_ptr = 0;
            e_pc = 0; e_pc4 = 0; e_instr = 0; e_valid = 0;
        end else begin
            m_st = !pc_write || !ifid_write;
            if (stream_on && !flush && !m_st && ifid_valid) begin
                chk("stream_pc", ifid_pc, s_ptr);
                chk("stream_instr", ifid_instr, mem(s_ptr));
                s_ptr = s_ptr + 32'd4;
            end
            if (flush) begin
                s_ptr = target;
                if (!m_kill) m_kaddr = m_pc;
                m_kill = !m_held && !imem_ack;
                m_held = 0; m_pc = target; e_instr = 0; e_valid = 0;
            end else if (m_kill) begin
                if (imem_ack) m_kill = 0;
                if (ifid_write) begin e_instr = 0; e_valid = 0; end
            end else if (m_held) begin
                if (!m_st) deliver(m_hbuf);
            end else if (imem_ack) begin
                if (m_st) begin m_held = 1; m_hbuf = mem(m_pc); end
                else deliver(mem(m_pc));
            end else if (ifid_write) begin
                e_instr = 0; e_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req", {31'd0, imem_req}, {31'd0, !m_held});
            chk("busy", {31'd0, fetch_busy}, {31'd0, !m_held});
            chk("addr", imem_addr, m_kill ? m_kaddr : m_pc);
            chk("valid", {31'd0, ifid_valid}, {31'd0, e_valid});
            chk("instr", ifid_instr, e_instr);
            if (e_valid) begin
                chk("pc", ifid_pc, e_pc);
                chk("pc4", ifid_pc4, e_pc4);
            end
        end
    end

    initial begin
        rst_n = 0; pc_write = 1; ifid_write = 1; flush = 0; target = 0; lat = 1; stream_on = 1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, 32'd0);
        chk("rst_pc", ifid_pc, 32'd0);
        chk("rst_pc4", ifid_pc4, 32'd0);
        rst_n = 1;
        repeat (2) @(negedge clk); ifid_is("seq0", 32'h0);
        @(negedge clk); ifid_is("seq4", 32'h4);
        @(negedge clk); ifid_is("seq8", 32'h8); lat = 3;
        @(negedge clk); ifid_is("seqC", 32'hC);
        @(negedge clk);
        chk("lat_bub1", {31'd0, ifid_valid}, 32'd0);
        chk("lat_nop1", ifid_instr, 32'd0);
        chk("lat_busy1", {31'd0, fetch_busy}, 32'd1);
        lat = 1;
        @(negedge clk);
        chk("lat_bub2", {31'd0, ifid_valid}, 32'd0);
        chk("lat_busy2", {31'd0, fetch_busy}, 32'd1);
        @(negedge clk); ifid_is("lat10", 32'h10);
        repeat (3) @(negedge clk); ifid_is("pre_stall", 32'h1C);
        pc_write = 0; ifid_write = 0;
        @(negedge clk); ifid_is("hold1", 32'h1C);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk); ifid_is("hold2", 32'h1C);
        pc_write = 1; ifid_write = 1;
        @(negedge clk); ifid_is("release", 32'h20);
        chk("release_addr", imem_addr, 32'h24);
        repeat (6) @(negedge clk); lat = 3;
        @(negedge clk); ifid_is("pre_flush", 32'h3C);
        chk("pre_flush_addr", imem_addr, 32'h40);
        flush = 1; target = 32'h100;
        @(negedge clk);
        chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
        chk("flush_instr", ifid_instr, 32'd0);
        chk("kill_addr", imem_addr, 32'h40);
        chk("kill_busy", {31'd0, fetch_busy}, 32'd1);
        flush = 0; lat = 1;
        repeat (2) @(negedge clk);
        chk("redirect_addr", imem_addr, 32'h100);
        @(negedge clk); ifid_is("target", 32'h100);
        pc_write = 0; ifid_write = 0;
        @(negedge clk);
        chk("hold_req2", {31'd0, imem_req}, 32'd0);
        flush = 1; target = 32'h200;
        @(negedge clk);
        chk("hold_flush_req", {31'd0, imem_req}, 32'd1);
        chk("hold_flush_addr", imem_addr, 32'h200);
        chk("hold_flush_valid", {31'd0, ifid_valid}, 32'd0);
        flush = 0; pc_write = 1; ifid_write = 1;
        @(negedge clk); ifid_is("after_hold_flush", 32'h200);
        flush = 1; target = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        flush = 0;
        @(negedge clk);
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        lat = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (i == 1500) begin
                rst_n = 0;
                #1;
                chk("async_rst_valid", {31'd0, ifid_valid}, 32'd0);
                chk("async_rst_addr", imem_addr, 32'h0);
                @(negedge clk);
                rst_n = 1;
            end else begin
                if (i == 3000) stream_on = 0;
                flush = $urandom_range(0, 15) == 0;
                target = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
                if (i < 3000) begin
                    pc_write = $urandom_range(0, 3) != 0;
                    ifid_write = pc_write;
                end else begin
                    pc_write = $urandom_range(0, 3) != 0;
                    ifid_write = $urandom_range(0, 3) != 0;
                end
            end
        end
        flush = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
